dm_lsu_mem: RTL

- Parametrised successor to the single-cycle data memory: byte-addressed, lane-correct (honours addr[1:0]), with registered synchronous read and a valid/ready request/response handshake.
- Sits between the MEM pipeline stage and the data array; the MEM stage stalls on req_ready/rsp_valid.
- Adds configurable depth, read latency, misalignment/range error reporting and correct sign/zero extension to 32 bits.

---
 rtl/dm_lsu_mem_pkg.sv | 49 ++++
 rtl/dm_lsu_mem_if.sv | 23 ++
 rtl/dm_lsu_mem_lane_align.sv | 43 ++++
 rtl/dm_lsu_mem.sv | 110 +++++++++++
 4 files changed

// File: rtl/dm_lsu_mem_pkg.sv
// Shared definitions for the data-memory LSU: access-type codes, FSM states,
// latency limits and address-offset helpers.
package dm_lsu_mem_pkg;

    localparam logic [2:0] DM_WORD              = 3'b000;
    localparam logic [2:0] DM_HALFWORD          = 3'b001;
    localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'b010;
    localparam logic [2:0] DM_BYTE              = 3'b011;
    localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'b100;

    localparam int READ_LATENCY_MAX = 4;
    localparam int CNT_W            = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_e;

    function automatic logic dm_type_legal(input logic [2:0] t);
        return (t <= DM_BYTE_UNSIGNED);
    endfunction

    function automatic logic dm_type_unsigned(input logic [2:0] t);
        return (t == DM_HALFWORD_UNSIGNED) || (t == DM_BYTE_UNSIGNED);
    endfunction

    function automatic logic dm_misaligned(input logic [2:0] t, input logic [1:0] a);
        logic r;
        case (t)
            DM_WORD:                           r = (a != 2'b00);
            DM_HALFWORD, DM_HALFWORD_UNSIGNED: r = a[0];
            default:                           r = 1'b0;
        endcase
        return r;
    endfunction

    // Natural alignment of the lane offset for the given access width.
    function automatic logic [1:0] dm_align_off(input logic [2:0] t, input logic [1:0] a);
        logic [1:0] r;
        case (t)
            DM_WORD:                           r = 2'b00;
            DM_HALFWORD, DM_HALFWORD_UNSIGNED: r = {a[1], 1'b0};
            default:                           r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dm_lsu_mem_if.sv
// Request/response bus between the MEM stage (master) and the data memory (slave).
interface dm_lsu_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_type;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_type, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_type, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_lsu_mem_lane_align.sv
// dm_lane_align: byte-lane mask, store-data replication and load extraction
// with sign/zero extension. Purely combinational; shared with the cache fill path.
module dm_lane_align
    import dm_lsu_mem_pkg::*;
(
    input  logic [2:0]  dm_type,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  mask,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata
);
    logic [15:0] half;
    logic [7:0]  bytev;

    assign half  = off[1] ? rword[31:16] : rword[15:0];
    assign bytev = rword[{off, 3'b000} +: 8];

    always_comb begin
        mask      = 4'b0000;
        wdata_rep = '0;
        rdata     = '0;
        case (dm_type)
            DM_WORD: begin
                mask      = 4'b1111;
                wdata_rep = wdata;
                rdata     = rword;
            end
            DM_HALFWORD, DM_HALFWORD_UNSIGNED: begin
                mask      = off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata     = (dm_type == DM_HALFWORD) ? {{16{half[15]}}, half} : {16'h0000, half};
            end
            DM_BYTE, DM_BYTE_UNSIGNED: begin
                mask      = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
                rdata     = (dm_type == DM_BYTE) ? {{24{bytev[7]}}, bytev} : {24'h000000, bytev};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/dm_lsu_mem.sv
// Byte-addressed data memory with valid/ready handshake and configurable read latency.
// DM_MISALIGN_TRAP_EN: misaligned half/word accesses raise rsp_err instead of being aligned.
module dm_lsu_mem
    import dm_lsu_mem_pkg::*;
#(
    parameter int DEPTH_WORDS  = 8192,
    parameter int READ_LATENCY = 1
) (
    input logic         clk,
    input logic         rstn,
    dm_lsu_mem_if.slave bus
);
    localparam int              IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

    dm_state_e         state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [31:0]       rdata_q, rdata_nxt;
    logic              err_q, err_nxt;
    logic [31:0]       mem [DEPTH_WORDS];

    logic              accept, err_type, err_mis, err_range, req_err;
    logic [1:0]        off;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        lane_mask;
    logic [31:0]       wdata_rep, load_ext;

    assign accept    = bus.req_valid && (state == ST_IDLE);
    assign err_type  = !dm_type_legal(bus.req_type) || (bus.req_we && dm_type_unsigned(bus.req_type));
`ifdef DM_MISALIGN_TRAP_EN
    assign err_mis   = dm_misaligned(bus.req_type, bus.req_addr[1:0]);
`else
    assign err_mis   = 1'b0;
`endif
    assign err_range = (bus.req_addr[31:2] >= 30'(DEPTH_WORDS));
    assign req_err   = err_type || err_mis || err_range;
    assign off       = dm_align_off(bus.req_type, bus.req_addr[1:0]);
    assign idx       = bus.req_addr[IDX_W+1:2];

    dm_lane_align u_align (
        .dm_type   (bus.req_type),
        .off       (off),
        .wdata     (bus.req_wdata),
        .rword     (mem[idx]),
        .mask      (lane_mask),
        .wdata_rep (wdata_rep),
        .rdata     (load_ext)
    );

    // Array is deliberately not reset; a store commits at its accept edge.
    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_mask[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rdata_q <= rdata_nxt;
            err_q   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rdata_nxt = rdata_q;
        err_nxt   = err_q;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    err_nxt   = req_err;
                    rdata_nxt = (bus.req_we || req_err) ? 32'h0 : load_ext;
                    if (READ_LATENCY == 1) begin
                        state_nxt = ST_RESP;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == '0) state_nxt = ST_RESP;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = ST_IDLE;
                    rdata_nxt = 32'h0;
                    err_nxt   = 1'b0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule
